// File: rtl/mar_wide_if.sv
// mar_wide_if: command and status signals between the sequencer and the address register.
interface mar_wide_if #(
  parameter int ADDR_W = 16
);
  logic [2:0] mode;
  logic [ADDR_W-1:0] addr;
  logic busy;
  logic load_done;
  logic wrap;
  modport master (output mode, input addr, busy, load_done, wrap);
  modport slave (input mode, output addr, busy, load_done, wrap);
endinterface

// File: rtl/mar_wide.sv
// mar_wide: multi-beat bus-loaded memory address register with inc/dec and wrap detection.
module mar_wide #(
  parameter int ADDR_W = 16,
  parameter int BUS_W = 8,
  parameter logic [ADDR_W-1:0] RESET_VALUE = '0
) (
  input logic clock,
  input logic reset,
  inout wire [BUS_W-1:0] data_bus,
  mar_wide_if.slave ctl
);
  localparam int BEATS = ADDR_W / BUS_W;
  localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST = BW'(BEATS - 1);
  typedef enum logic [1:0] {IDLE, LOADING, DRIVING} state_t;
  state_t state, state_n;
  logic [BW-1:0] beat, beat_n, lb, db;
  logic [ADDR_W-1:0] stg, stg_n, addr_n;
  logic ld_n, wr_n;
  // A LOAD or DRIVE that does not continue its own sequence restarts at beat 0.
  assign lb = state == LOADING ? beat : '0;
  assign db = state == DRIVING ? beat : '0;
  assign data_bus = ctl.mode == 3'b011 ? ctl.addr[db*BUS_W +: BUS_W] : 'z;
  assign ctl.busy = state != IDLE;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      beat <= '0;
      stg <= '0;
      ctl.addr <= RESET_VALUE;
      ctl.load_done <= 1'b0;
      ctl.wrap <= 1'b0;
    end else begin
      state <= state_n;
      beat <= beat_n;
      stg <= stg_n;
      ctl.addr <= addr_n;
      ctl.load_done <= ld_n;
      ctl.wrap <= wr_n;
    end
  always_comb begin
    state_n = state;
    beat_n = beat;
    stg_n = stg;
    addr_n = ctl.addr;
    ld_n = 1'b0;
    wr_n = 1'b0;
    case (ctl.mode)
      3'b001, 3'b100, 3'b101, 3'b110: begin
        state_n = IDLE;
        beat_n = '0;
        stg_n = '0;
        addr_n = ctl.mode == 3'b001 ? RESET_VALUE :
                 ctl.mode == 3'b100 ? ctl.addr + 1'b1 :
                 ctl.mode == 3'b101 ? ctl.addr - 1'b1 : ctl.addr;
        wr_n = (ctl.mode == 3'b100 && &ctl.addr) || (ctl.mode == 3'b101 && ~|ctl.addr);
      end
      3'b010: begin
        stg_n = state == LOADING ? stg : '0;
        stg_n[lb*BUS_W +: BUS_W] = data_bus;
        state_n = lb == LAST ? IDLE : LOADING;
        beat_n = lb == LAST ? '0 : lb + 1'b1;
        addr_n = lb == LAST ? stg_n : ctl.addr;
        ld_n = lb == LAST;
        if (lb == LAST) stg_n = '0;
      end
      3'b011: begin
        stg_n = '0;
        state_n = db == LAST ? IDLE : DRIVING;
        beat_n = db == LAST ? '0 : db + 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_mar_wide.sv
// tb_mar_wide: directed vectors against hand-computed values for the 16/8 configuration.
module tb_mar_wide;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [7:0] tb_drv = '0;
  logic tb_en = 1'b0;
  wire [7:0] data_bus;
  int errors = 0;
  int checks = 0;
  mar_wide_if #(.ADDR_W(16)) ctl ();
  mar_wide #(.ADDR_W(16), .BUS_W(8), .RESET_VALUE(16'h0000)) dut (
    .clock(clock),
    .reset(reset),
    .data_bus(data_bus),
    .ctl(ctl.slave)
  );
  assign data_bus = tb_en ? tb_drv : 8'hzz;
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic put(input logic [2:0] m, input logic [7:0] d = 8'h00, input logic en = 1'b0);
    ctl.mode = m;
    tb_drv = d;
    tb_en = en;
  endtask
  task automatic tick;
    @(posedge clock);
    #2;
  endtask
  task automatic cyc(input logic [2:0] m, input logic [7:0] d = 8'h00, input logic en = 1'b0);
    put(m, d, en);
    tick();
  endtask
  task automatic load16(input logic [15:0] v);
    cyc(3'b010, v[7:0], 1'b1);
    cyc(3'b010, v[15:8], 1'b1);
    cyc(3'b000);
  endtask
  initial begin
    put(3'b000);
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;
    chk("rst_addr", 32'(ctl.addr), 32'h0000);
    chk("rst_busy", 32'(ctl.busy), 32'h0);
    cyc(3'b010, 8'hEF, 1'b1);
    chk("ld1_busy", 32'(ctl.busy), 32'h1);
    chk("ld1_addr", 32'(ctl.addr), 32'h0000);
    cyc(3'b010, 8'hBE, 1'b1);
    chk("ld2_addr", 32'(ctl.addr), 32'hBEEF);
    chk("ld2_done", 32'(ctl.load_done), 32'h1);
    cyc(3'b000);
    chk("ld_done_clr", 32'(ctl.load_done), 32'h0);
    // Asynchronous reset mid-cycle, mid-sequence.
    cyc(3'b010, 8'h34, 1'b1);
    put(3'b000);
    #1 reset = 1'b1;
    #1;
    chk("arst_addr", 32'(ctl.addr), 32'h0000);
    chk("arst_busy", 32'(ctl.busy), 32'h0);
    chk("arst_done", 32'(ctl.load_done), 32'h0);
    chk("arst_wrap", 32'(ctl.wrap), 32'h0);
    chk("arst_bus_z", 32'(data_bus === 8'hzz), 32'h1);
    #1 reset = 1'b0;
    cyc(3'b010, 8'h34, 1'b1);
    chk("b1_addr", 32'(ctl.addr), 32'h0000);
    chk("b1_busy", 32'(ctl.busy), 32'h1);
    cyc(3'b010, 8'h12, 1'b1);
    chk("b2_addr", 32'(ctl.addr), 32'h1234);
    chk("b2_done", 32'(ctl.load_done), 32'h1);
    chk("b2_busy", 32'(ctl.busy), 32'h0);
    cyc(3'b000);
    chk("b2_done_clr", 32'(ctl.load_done), 32'h0);
    put(3'b011);
    #1 chk("drv0", 32'(data_bus), 32'h34);
    tick();
    chk("drv1", 32'(data_bus), 32'h12);
    chk("drv1_busy", 32'(ctl.busy), 32'h1);
    tick();
    chk("drv2", 32'(data_bus), 32'h34);
    chk("drv2_busy", 32'(ctl.busy), 32'h0);
    tick();
    put(3'b000);
    #1 chk("drv_nop_z", 32'(data_bus === 8'hzz), 32'h1);
    chk("drv_nop_busy", 32'(ctl.busy), 32'h1);
    tick();
    chk("drv_pause", 32'(data_bus === 8'hzz), 32'h1);
    put(3'b011);
    #1 chk("drv_resume", 32'(data_bus), 32'h12);
    tick();
    chk("drv_end_busy", 32'(ctl.busy), 32'h0);
    load16(16'hFFFF);
    cyc(3'b100);
    chk("inc_wrap_addr", 32'(ctl.addr), 32'h0000);
    chk("inc_wrap", 32'(ctl.wrap), 32'h1);
    cyc(3'b000);
    chk("wrap_clr", 32'(ctl.wrap), 32'h0);
    cyc(3'b101);
    chk("dec_wrap_addr", 32'(ctl.addr), 32'hFFFF);
    chk("dec_wrap", 32'(ctl.wrap), 32'h1);
    cyc(3'b101);
    chk("dec_addr", 32'(ctl.addr), 32'hFFFE);
    chk("dec_nowrap", 32'(ctl.wrap), 32'h0);
    load16(16'h1234);
    cyc(3'b100);
    chk("inc_addr", 32'(ctl.addr), 32'h1235);
    chk("inc_nowrap", 32'(ctl.wrap), 32'h0);
    load16(16'h1234);
    cyc(3'b010, 8'hAA, 1'b1);
    cyc(3'b100);
    chk("abort_inc_addr", 32'(ctl.addr), 32'h1235);
    chk("abort_inc_busy", 32'(ctl.busy), 32'h0);
    chk("abort_inc_done", 32'(ctl.load_done), 32'h0);
    cyc(3'b010, 8'h01, 1'b1);
    chk("reload_busy", 32'(ctl.busy), 32'h1);
    cyc(3'b010, 8'h00, 1'b1);
    chk("reload_addr", 32'(ctl.addr), 32'h0001);
    cyc(3'b010, 8'h55, 1'b1);
    reset = 1'b1;
    #1 reset = 1'b0;
    chk("rst_seq_busy", 32'(ctl.busy), 32'h0);
    chk("rst_seq_addr", 32'(ctl.addr), 32'h0000);
    cyc(3'b010, 8'h66, 1'b1);
    chk("rst_seq_done0", 32'(ctl.load_done), 32'h0);
    chk("rst_seq_mid", 32'(ctl.addr), 32'h0000);
    cyc(3'b010, 8'h77, 1'b1);
    chk("rst_seq_addr2", 32'(ctl.addr), 32'h7766);
    chk("rst_seq_done1", 32'(ctl.load_done), 32'h1);
    cyc(3'b000);
    chk("rst_seq_done2", 32'(ctl.load_done), 32'h0);
    cyc(3'b001);
    chk("clear_addr", 32'(ctl.addr), 32'h0000);
    load16(16'h3322);
    cyc(3'b010, 8'h11, 1'b1);
    cyc(3'b110);
    chk("abort_addr", 32'(ctl.addr), 32'h3322);
    chk("abort_busy", 32'(ctl.busy), 32'h0);
    cyc(3'b010, 8'h44, 1'b1);
    put(3'b011);
    #1 chk("conf_drv0", 32'(data_bus), 32'h22);
    tick();
    chk("conf_drv1", 32'(data_bus), 32'h33);
    chk("conf_busy", 32'(ctl.busy), 32'h1);
    cyc(3'b010, 8'h01, 1'b1);
    chk("conf_ld_busy", 32'(ctl.busy), 32'h1);
    chk("conf_ld_addr", 32'(ctl.addr), 32'h3322);
    cyc(3'b010, 8'h02, 1'b1);
    chk("conf_ld_final", 32'(ctl.addr), 32'h0201);
    chk("conf_ld_done", 32'(ctl.load_done), 32'h1);
    cyc(3'b111);
    chk("rsvd_addr", 32'(ctl.addr), 32'h0201);
    chk("rsvd_bus_z", 32'(data_bus === 8'hzz), 32'h1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
